// File: rtl/alu_op_sequencer.sv
// Purpose : multicycle command-driven master for an external combinational 16-bit ALU.
//           It has an 8x16 register file, repeats the op (A <- result) and writes the result back.
// Latency : from command accept to rsp_valid is 2+rep clock edges (rep = extra iterations).
// Backpr. : one command at a time. cmd_ready is high only in IDLE. rsp_* hold until rsp_ready.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_opc/srca/srcb/dst/cin/rep command fields
//   rsp_valid/rsp_ready           response handshake
//   rsp_data/rsp_zer/rsp_neg      response payload
//   ld_en/ld_addr/ld_data         register-file preload (honoured in IDLE only)
//   alu_inA/inB/inC/opc           registered operands to the ALU
//   alu_outW/zer/neg              combinational ALU result and flags
module alu_op_sequencer #(
    parameter int NREG = 8,
    parameter int REPW = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_opc,
    input  logic [$clog2(NREG)-1:0] cmd_srca,
    input  logic [$clog2(NREG)-1:0] cmd_srcb,
    input  logic [$clog2(NREG)-1:0] cmd_dst,
    input  logic                    cmd_cin,
    input  logic [REPW-1:0]         cmd_rep,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [15:0]             rsp_data,
    output logic                    rsp_zer,
    output logic                    rsp_neg,
    input  logic                    ld_en,
    input  logic [$clog2(NREG)-1:0] ld_addr,
    input  logic [15:0]             ld_data,
    output logic [15:0]             alu_inA,
    output logic [15:0]             alu_inB,
    output logic                    alu_inC,
    output logic [2:0]              alu_opc,
    input  logic [15:0]             alu_outW,
    input  logic                    alu_zer,
    input  logic                    alu_neg
);
    localparam int IW = $clog2(NREG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          stateNxt;

    logic [15:0]     regFile [NREG];
    logic [2:0]      opcLat;
    logic [IW-1:0]   srcaLat;
    logic [IW-1:0]   srcbLat;
    logic [IW-1:0]   dstLat;
    logic            cinLat;
    logic [REPW-1:0] repLat;
    logic [REPW-1:0] repCnt;

    logic            cmdAccept;

    assign cmd_ready = (state == IDLE);
    assign cmdAccept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (cmdAccept) stateNxt = FETCH;
            FETCH:   stateNxt = EXEC;
            EXEC:    if (repCnt == '0) stateNxt = RESP;
            RESP:    if (rsp_ready) stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regFile[i] <= '0;
            end
            opcLat    <= '0;
            srcaLat   <= '0;
            srcbLat   <= '0;
            dstLat    <= '0;
            cinLat    <= 1'b0;
            repLat    <= '0;
            repCnt    <= '0;
            alu_inA   <= '0;
            alu_inB   <= '0;
            alu_inC   <= 1'b0;
            alu_opc   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zer   <= 1'b0;
            rsp_neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The preload lands on this same edge, so a command accepted
                    // now sees the new value when FETCH reads the file.
                    if (ld_en) begin
                        regFile[ld_addr] <= ld_data;
                    end
                    if (cmdAccept) begin
                        opcLat  <= cmd_opc;
                        srcaLat <= cmd_srca;
                        srcbLat <= cmd_srcb;
                        dstLat  <= cmd_dst;
                        cinLat  <= cmd_cin;
                        repLat  <= cmd_rep;
                    end
                end
                FETCH: begin
                    alu_inA <= regFile[srcaLat];
                    alu_inB <= regFile[srcbLat];
                    alu_inC <= cinLat;
                    alu_opc <= opcLat;
                    repCnt  <= repLat;
                end
                EXEC: begin
                    if (repCnt != '0) begin
                        // Feed the result back as operand A. B, C and opc stay as fetched.
                        alu_inA <= alu_outW;
                        repCnt  <= repCnt - 1'b1;
                    end else begin
                        regFile[dstLat] <= alu_outW;
                        rsp_data        <= alu_outW;
                        rsp_zer         <= alu_zer;
                        rsp_neg         <= alu_neg;
                        rsp_valid       <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opc;
    logic [2:0]  cmd_srca;
    logic [2:0]  cmd_srcb;
    logic [2:0]  cmd_dst;
    logic        cmd_cin;
    logic [3:0]  cmd_rep;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_zer;
    logic        rsp_neg;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_inA;
    logic [15:0] alu_inB;
    logic        alu_inC;
    logic [2:0]  alu_opc;
    logic [15:0] alu_outW;
    logic        alu_zer;
    logic        alu_neg;

    int          vecCnt  = 0;
    int          failCnt = 0;
    logic [15:0] modelRegs [8];

    always #5 clk = ~clk;

    alu_op_sequencer #(.NREG(8), .REPW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_opc   (cmd_opc),
        .cmd_srca  (cmd_srca),
        .cmd_srcb  (cmd_srcb),
        .cmd_dst   (cmd_dst),
        .cmd_cin   (cmd_cin),
        .cmd_rep   (cmd_rep),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zer   (rsp_zer),
        .rsp_neg   (rsp_neg),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .alu_inA   (alu_inA),
        .alu_inB   (alu_inB),
        .alu_inC   (alu_inC),
        .alu_opc   (alu_opc),
        .alu_outW  (alu_outW),
        .alu_zer   (alu_zer),
        .alu_neg   (alu_neg)
    );

    // ALU: 0 negate A, 1 increment A, 2 A+B+C, 3 A-B, 4 AND, 5 pass A, 6 XOR, 7 NOT A
    function automatic logic [15:0] aluFn(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
        case (op)
            3'd0:    return 16'd0 - a;
            3'd1:    return a + 16'd1;
            3'd2:    return a + b + {15'd0, c};
            3'd3:    return a - b;
            3'd4:    return a & b;
            3'd5:    return a;
            3'd6:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    always_comb begin
        alu_outW = aluFn(alu_opc, alu_inA, alu_inB, alu_inC);
        alu_zer  = (alu_outW == 16'd0);
        alu_neg  = alu_outW[15];
    end

    task automatic chkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            failCnt++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic doLoad(input logic [2:0] addr, input logic [15:0] val);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = val;
        @(posedge clk); #1;
        ld_en = 1'b0;
        modelRegs[addr] = val;
    endtask

    // Issues one command and checks the response against the iteration model.
    // loadSame preloads srca on the accept edge; stall holds rsp_ready low while junk is driven.
    task automatic doCmd(input logic [2:0] opc, input logic [2:0] srca, input logic [2:0] srcb,
                         input logic [2:0] dst, input logic cin, input logic [3:0] rep,
                         input bit loadSame, input logic [15:0] loadVal, input int stall);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] expA [$];
        logic [15:0] res;
        logic [15:0] held;
        int          cnt;
        cmd_opc   = opc;
        cmd_srca  = srca;
        cmd_srcb  = srcb;
        cmd_dst   = dst;
        cmd_cin   = cin;
        cmd_rep   = rep;
        cmd_valid = 1'b1;
        if (loadSame) begin
            ld_en   = 1'b1;
            ld_addr = srca;
            ld_data = loadVal;
        end
        chkVal("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        ld_en     = 1'b0;
        if (loadSame) modelRegs[srca] = loadVal;

        a = modelRegs[srca];
        b = modelRegs[srcb];
        res = a;
        for (int i = 0; i <= int'(rep); i++) begin
            expA.push_back(a);
            res = aluFn(opc, a, b, cin);
            a = res;
        end

        cnt = 0;
        while (cnt < 40 && !rsp_valid) begin
            if (cnt >= 1 && cnt <= int'(rep) + 1) begin
                chkVal("alu_inA_iter", {16'd0, alu_inA}, {16'd0, expA[cnt-1]});
                chkVal("alu_inB_const", {16'd0, alu_inB}, {16'd0, b});
                chkVal("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
            end
            @(posedge clk); #1;
            cnt++;
        end
        chkVal("latency", cnt, 2 + int'(rep));
        chkVal("alu_opc", {29'd0, alu_opc}, {29'd0, opc});
        chkVal("alu_inC", {31'd0, alu_inC}, {31'd0, cin});
        chkVal("rsp_data", {16'd0, rsp_data}, {16'd0, res});
        chkVal("rsp_zer", {31'd0, rsp_zer}, {31'd0, (res == 16'd0)});
        chkVal("rsp_neg", {31'd0, rsp_neg}, {31'd0, res[15]});

        held = rsp_data;
        for (int s = 0; s < stall; s++) begin
            cmd_valid = 1'b1;
            cmd_opc   = 3'($urandom);
            cmd_dst   = 3'($urandom);
            ld_en     = 1'b1;
            ld_addr   = 3'($urandom);
            ld_data   = 16'($urandom);
            @(posedge clk); #1;
            chkVal("stall_valid", {31'd0, rsp_valid}, 32'd1);
            chkVal("stall_data", {16'd0, rsp_data}, {16'd0, held});
            chkVal("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        ld_en     = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chkVal("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        chkVal("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
        modelRegs[dst] = res;
    endtask

    task automatic readBack(input logic [2:0] idx);
        doCmd(3'd5, idx, idx, idx, 1'b0, 4'd0, 1'b0, 16'd0, 0);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        #1;
        chkVal("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chkVal("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chkVal("rst_alu_inA", {16'd0, alu_inA}, 32'd0);
        chkVal("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        for (int i = 0; i < 8; i++) modelRegs[i] = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_opc   = '0;
        cmd_srca  = '0;
        cmd_srcb  = '0;
        cmd_dst   = '0;
        cmd_cin   = 1'b0;
        cmd_rep   = '0;
        rsp_ready = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        for (int i = 0; i < 8; i++) modelRegs[i] = 16'd0;

        #2;
        applyReset();
        for (int i = 0; i < 8; i++) readBack(3'(i));

        // Add with carry, then read the destination back.
        doLoad(3'd1, 16'h0005);
        doLoad(3'd2, 16'h0003);
        doCmd(3'd2, 3'd1, 3'd2, 3'd3, 1'b1, 4'd0, 1'b0, 16'd0, 0);
        chkVal("add_result", {16'd0, rsp_data}, 32'h0009);
        readBack(3'd3);

        // Negate gives a negative result.
        doCmd(3'd0, 3'd1, 3'd1, 3'd4, 1'b0, 4'd0, 1'b0, 16'd0, 0);
        chkVal("neg_result", {16'd0, rsp_data}, 32'hFFFB);

        // Repeated increment through zero. The intermediate zero is not reported.
        doLoad(3'd1, 16'hFFFE);
        doCmd(3'd1, 3'd1, 3'd0, 3'd1, 1'b0, 4'd3, 1'b0, 16'd0, 0);
        chkVal("inc_wrap_result", {16'd0, rsp_data}, 32'h0002);
        chkVal("inc_wrap_zer", {31'd0, rsp_zer}, 32'd0);

        // Stalled response with junk commands and loads: all must be ignored.
        doCmd(3'd6, 3'd2, 3'd3, 3'd5, 1'b0, 4'd0, 1'b0, 16'd0, 5);
        for (int i = 0; i < 8; i++) readBack(3'(i));

        // Load and accept on the same edge.
        doCmd(3'd2, 3'd7, 3'd7, 3'd0, 1'b0, 4'd0, 1'b1, 16'h1234, 0);
        chkVal("same_edge_load", {16'd0, rsp_data}, 32'h2468);

        // Randomized commands.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1) doLoad(3'($urandom), 16'($urandom));
            doCmd(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                  4'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
                  int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 8; i++) readBack(3'(i));

        // Reset in the middle of EXEC of a long repeat: no writeback, everything cleared.
        doLoad(3'd6, 16'h00AA);
        doLoad(3'd2, 16'h0011);
        cmd_opc   = 3'd2;
        cmd_srca  = 3'd2;
        cmd_srcb  = 3'd2;
        cmd_dst   = 3'd6;
        cmd_cin   = 1'b0;
        cmd_rep   = 4'd5;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chkVal("pre_abort_valid", {31'd0, rsp_valid}, 32'd0);
        applyReset();
        for (int i = 0; i < 8; i++) readBack(3'(i));

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, failCnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
